lcd_write_sequencer: RTL and testbench
======================================

// Module: lcd_write_sequencer
// PURPOSE
//  Sequences the HD44780-style character LCD bus (LCD_E/LCD_RS/LCD_RW/LCD_data) from a valid/ready byte stream.
//  After reset it runs a power-up wait and a fixed init script. Then, for each accepted byte it generates
//  address setup, the E pulse, the hold time and the post-command busy wait.
//  Sits between the display-update logic and the LCD pins. Replaces raw, CPU-timed Avalon pokes of the LCD.
// PARAMETERS (all counts in clk cycles, each >= 1; defaults sized for 50 MHz)
//  T_PWRUP     750000  wait after reset before the first init command (15 ms)
//  T_AS        2       RS/data valid before E rises (40 ns)
//  T_EPW       12      E high width (240 ns)
//  T_HOLD      2       RS/data held after E falls (40 ns)
//  T_CMD_WAIT  2000    post-write wait for ordinary commands and data (40 us)
//  T_CLR_WAIT  82000   post-write wait for clear/home (1.64 ms)
//  INIT_EN     1       1 = run power-up wait + init script; 0 = go straight to ready
//  CNT_W       20      delay counter width; must hold max(T_*)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  req_valid  in   1  request present
//  req_ready  out  1  block accepts a request this cycle
//  req_rs     in   1  0 = command, 1 = display data
//  req_data   in   8  byte to write
//  init_done  out  1  init script finished; stays 1 until reset
//  LCD_E      out  1  LCD enable strobe
//  LCD_RS     out  1  LCD register select
//  LCD_RW     out  1  LCD read/write; held 0 (write-only)
//  LCD_data   out  8  LCD data bus, always driven
// BEHAVIOUR
//  Reset: state=PWRUP (or IDLE if INIT_EN=0); all outputs 0; counter and init index cleared.
//  Reset mid-transfer: LCD_E is 0 on the first cycle after the reset edge, and the sequence restarts from PWRUP.
//  States: PWRUP -> INIT_ISSUE -> SETUP -> EPULSE -> HOLD -> WAIT -> (INIT_ISSUE | IDLE).
//  PWRUP: counts T_PWRUP cycles, then goes to INIT_ISSUE.
//  INIT_ISSUE: loads script byte[idx] with RS=0, then goes to SETUP.
//   Script: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (6 entries).
//  IDLE: req_ready = init_done & (state==IDLE). It is combinational from state only, never from req_valid.
//  Handshake: transfer happens when req_valid & req_ready are both high at a rising edge.
//   The edge latches req_rs/req_data into LCD_RS/LCD_data and enters SETUP.
//   req_* inputs are ignored at all other times.
//  SETUP: T_AS cycles, E=0.
//  EPULSE: T_EPW cycles, E=1.
//  HOLD: T_HOLD cycles, E=0.
//  WAIT: E=0 for Tw cycles.
//   Tw = T_CLR_WAIT if RS=0 and data[7:2]==0 (0x00-0x03); otherwise Tw = T_CMD_WAIT.
//  RS and data are stable from SETUP through the end of WAIT. They change only on the next acceptance or init load.
//  Latency: if acceptance is at the edge ending cycle k, req_ready is next high in cycle k+1+T_AS+T_EPW+T_HOLD+Tw.
//  Throughput: at most one byte in flight; no buffering.
//  Init sequencing: WAIT exit with idx<5 -> idx++, goes to INIT_ISSUE.
//   WAIT exit with idx==5 -> init_done=1, goes to IDLE.
//   With INIT_EN=0, init_done=1 from the first cycle after reset deasserts.
//  Counters: load phase length minus 1 on entry and decrement to 0. No wrap; exit on 0.
//   A value of 1 therefore gives exactly 1 cycle in that phase.
//  LCD_E is registered (glitch-free). LCD_RW is constant 0.
// TESTING (sim params: T_PWRUP=10 T_AS=2 T_EPW=4 T_HOLD=2 T_CMD_WAIT=5 T_CLR_WAIT=20)
//  1. Reset release, INIT_EN=1: E stays 0 for 10 cycles, then exactly 6 E pulses with data 38,38,38,0C,01,06 at E rise.
//     The gap after the 0x01 pulse is 20 wait cycles; the others are 5. init_done and req_ready rise together after the last wait.
//  2. Data write 0x41, rs=1, held valid: accepted in 1 cycle. E high for exactly 4 cycles, starting 2 cycles after acceptance.
//     RS=1 and data=0x41 stable throughout. req_ready returns 14 cycles after acceptance.
//  3. Command 0x01 vs 0x80 back-to-back: ready gap is 29 cycles after 0x01 and 14 cycles after 0x80.
//     The second request is held valid across the busy window and is accepted on the first ready cycle, not before.
//  4. req_valid toggled during SETUP/EPULSE/WAIT with changing data: LCD_data/LCD_RS unchanged.
//     No extra E pulse; no extra acceptance.
//  5. reset asserted for 1 cycle while E=1: E=0 on the next cycle. Outputs are 0 and req_ready is 0.
//     The full PWRUP and init script replays.
//  6. INIT_EN=0: req_ready=1 and init_done=1 on the first cycle after reset. No E pulse occurs before the first request.

Source files
------------

// File: rtl/lcd_write_sequencer.sv
// HD44780-style LCD write sequencer: power-up wait, init script, then
// one valid/ready byte at a time with setup, E pulse, hold and busy wait.
module lcd_write_sequencer #(
    parameter int T_PWRUP    = 750000,
    parameter int T_AS       = 2,
    parameter int T_EPW      = 12,
    parameter int T_HOLD     = 2,
    parameter int T_CMD_WAIT = 2000,
    parameter int T_CLR_WAIT = 82000,
    parameter bit INIT_EN    = 1'b1,
    parameter int CNT_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_data
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_EPULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] C_PWR  = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] C_AS   = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] C_EPW  = CNT_W'(T_EPW - 1);
    localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] C_CMD  = CNT_W'(T_CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] C_CLR  = CNT_W'(T_CLR_WAIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'd5;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             is_clr;

    function automatic logic [7:0] script_byte(input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            3'd0, 3'd1, 3'd2: b = 8'h38;
            3'd3:             b = 8'h0C;
            3'd4:             b = 8'h01;
            3'd5:             b = 8'h06;
            default:          b = 8'h00;
        endcase
        return b;
    endfunction

    // Clear display and return home (0x00-0x03) need the long busy wait
    assign is_clr    = !LCD_RS && (LCD_data[7:2] == 6'd0);
    assign req_ready = init_done && (state == S_IDLE);
    assign LCD_RW    = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT_EN ? S_PWRUP : S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            init_done <= 1'b0;
            LCD_E     <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_data  <= 8'h00;
        end else begin
            if (!INIT_EN) begin
                init_done <= 1'b1;
            end
            unique case (state)
                S_PWRUP: begin
                    if (cnt == C_PWR) begin
                        cnt   <= '0;
                        state <= S_INIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INIT: begin
                    LCD_RS   <= 1'b0;
                    LCD_data <= script_byte(idx);
                    cnt      <= C_AS;
                    state    <= S_SETUP;
                end
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        LCD_RS   <= req_rs;
                        LCD_data <= req_data;
                        cnt      <= C_AS;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        LCD_E <= 1'b1;
                        cnt   <= C_EPW;
                        state <= S_EPULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EPULSE: begin
                    if (cnt == '0) begin
                        LCD_E <= 1'b0;
                        cnt   <= C_HOLD;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= is_clr ? C_CLR : C_CMD;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (init_done) begin
                        state <= S_IDLE;
                    end else if (idx == IDX_LAST) begin
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_INIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: init script timing, random writes with
// bus noise, reset mid-pulse, and the no-init variant.
module tb_lcd_write_sequencer;

    localparam int T_PWRUP = 10;
    localparam int T_AS    = 2;
    localparam int T_EPW   = 4;
    localparam int T_HOLD  = 2;
    localparam int T_CMD   = 5;
    localparam int T_CLR   = 20;
    localparam int LIM     = 300;

    logic       clk = 1'b0;
    logic       reset, reset2;
    logic       req_valid, req_rs;
    logic [7:0] req_data;
    logic       req_ready, init_done, LCD_E, LCD_RS, LCD_RW;
    logic [7:0] LCD_data;
    logic       req_valid2, req_rs2;
    logic [7:0] req_data2;
    logic       req_ready2, init_done2, LCD_E2, LCD_RS2, LCD_RW2;
    logic [7:0] LCD_data2;

    int n_chk = 0;
    int n_fail = 0;
    int rw_bad = 0;
    logic [7:0] script [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_write_sequencer #(
        .T_PWRUP(T_PWRUP), .T_AS(T_AS), .T_EPW(T_EPW), .T_HOLD(T_HOLD),
        .T_CMD_WAIT(T_CMD), .T_CLR_WAIT(T_CLR), .INIT_EN(1'b1), .CNT_W(20)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_data(req_data), .init_done(init_done),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_data(LCD_data)
    );

    lcd_write_sequencer #(
        .T_PWRUP(T_PWRUP), .T_AS(T_AS), .T_EPW(T_EPW), .T_HOLD(T_HOLD),
        .T_CMD_WAIT(T_CMD), .T_CLR_WAIT(T_CLR), .INIT_EN(1'b0), .CNT_W(20)
    ) dut2 (
        .clk(clk), .reset(reset2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_rs(req_rs2), .req_data(req_data2), .init_done(init_done2),
        .LCD_E(LCD_E2), .LCD_RS(LCD_RS2), .LCD_RW(LCD_RW2), .LCD_data(LCD_data2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (LCD_RW !== 1'b0 || LCD_RW2 !== 1'b0) rw_bad++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Busy wait after a write: clear/home commands are slow
    function automatic int tw(input logic rs, input logic [7:0] d);
        return (!rs && d < 8'h04) ? T_CLR : T_CMD;
    endfunction

    task automatic drive_junk();
        req_valid = 1'($urandom);
        req_rs    = 1'($urandom);
        req_data  = 8'($urandom);
    endtask

    task automatic meas(
        input  logic ers, input logic [7:0] ed,
        input  bit chk_pre, input bit junk,
        output int pre, output int width, output int low, output int mism,
        output int endr, output int done_seen, output int rrs, output int rd
    );
        pre = 0; width = 0; low = 0; mism = 0;
        endr = 0; done_seen = 0; rrs = 0; rd = 0;
        while (!LCD_E && pre < LIM) begin
            if (chk_pre && (LCD_RS !== ers || LCD_data !== ed)) mism++;
            if (init_done) done_seen++;
            if (junk) drive_junk();
            pre++;
            @(negedge clk);
        end
        rrs = int'(LCD_RS);
        rd  = int'(LCD_data);
        while (LCD_E && width < LIM) begin
            if (LCD_RS !== ers || LCD_data !== ed) mism++;
            if (init_done) done_seen++;
            if (junk) drive_junk();
            width++;
            @(negedge clk);
        end
        while (!LCD_E && !req_ready && low < LIM) begin
            if (low < T_HOLD + tw(ers, ed) &&
                (LCD_RS !== ers || LCD_data !== ed)) mism++;
            if (init_done) done_seen++;
            if (junk) drive_junk();
            low++;
            @(negedge clk);
        end
        endr = int'(req_ready);
    endtask

    task automatic run_init();
        int pre, width, low, mism, endr, ds, rrs, rd, t;
        for (int i = 0; i < 6; i++) begin
            meas(1'b0, script[i], 1'b0, 1'b0,
                 pre, width, low, mism, endr, ds, rrs, rd);
            t = tw(1'b0, script[i]);
            check($sformatf("init%0d_pre", i), pre,
                  (i == 0) ? T_PWRUP + 1 + T_AS : 0);
            check($sformatf("init%0d_epw", i), width, T_EPW);
            check($sformatf("init%0d_data", i), rd, int'(script[i]));
            check($sformatf("init%0d_rs", i), rrs, 0);
            check($sformatf("init%0d_gap", i), low,
                  (i < 5) ? T_HOLD + t + 1 + T_AS : T_HOLD + t);
            check($sformatf("init%0d_ready", i), endr, (i == 5) ? 1 : 0);
            check($sformatf("init%0d_stable", i), mism, 0);
            check($sformatf("init%0d_done_early", i), ds, 0);
        end
        check("init_done_end", int'(init_done), 1);
        check("init_ready_end", int'(req_ready), 1);
    endtask

    task automatic do_write(
        input logic rs, input logic [7:0] d, input bit junk,
        input bit hold, input logic nrs, input logic [7:0] nd
    );
        int w, pre, width, low, mism, endr, ds, rrs, rd, t;
        string tg;
        tg = $sformatf("wr_%0d_%02h", rs, d);
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        w = 0;
        while (!req_ready && w < LIM) begin
            @(negedge clk);
            w++;
        end
        check({tg, "_ready_in"}, int'(req_ready), 1);
        @(negedge clk);
        if (hold) begin
            req_rs   = nrs;
            req_data = nd;
        end else if (!junk) begin
            req_valid = 1'b0;
        end
        meas(rs, d, 1'b1, junk, pre, width, low, mism, endr, ds, rrs, rd);
        t = tw(rs, d);
        check({tg, "_setup"}, pre, T_AS);
        check({tg, "_epw"}, width, T_EPW);
        check({tg, "_rs"}, rrs, int'(rs));
        check({tg, "_data"}, rd, int'(d));
        check({tg, "_busy"}, low, T_HOLD + t);
        check({tg, "_ready_back"}, endr, 1);
        check({tg, "_latency"}, 1 + pre + width + low,
              1 + T_AS + T_EPW + T_HOLD + t);
        check({tg, "_stable"}, mism, 0);
    endtask

    initial begin
        int cnt, w;
        logic       rs;
        logic [7:0] d;
        reset = 1'b1; reset2 = 1'b1;
        req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        req_valid2 = 1'b0; req_rs2 = 1'b0; req_data2 = 8'h00;
        repeat (3) @(negedge clk);

        reset2 = 1'b0;
        check("n_rst_e", int'(LCD_E2), 0);
        check("n_rst_ready", int'(req_ready2), 0);
        check("n_rst_done", int'(init_done2), 0);
        check("n_rst_bus", int'({LCD_RS2, LCD_data2}), 0);
        @(negedge clk);
        check("n_ready_first", int'(req_ready2), 1);
        check("n_done_first", int'(init_done2), 1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (LCD_E2) cnt++;
        end
        check("n_no_epulse", cnt, 0);
        check("n_ready_held", int'(req_ready2), 1);

        check("rst_e", int'(LCD_E), 0);
        check("rst_bus", int'({LCD_RS, LCD_data}), 0);
        reset = 1'b0;
        run_init();

        do_write(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00);
        do_write(1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h80);
        do_write(1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00);
        do_write(1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00);
        do_write(1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00);
        do_write(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            rs = 1'($urandom);
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 7));
            req_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_write(rs, d, 1'($urandom), 1'b0, 1'b0, 8'h00);
        end

        req_valid = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (LCD_E) cnt++;
        end
        check("idle_no_epulse", cnt, 0);
        check("idle_ready", int'(req_ready), 1);

        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (!LCD_E && w < LIM) begin
            @(negedge clk);
            w++;
        end
        check("mid_e_high", int'(LCD_E), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_e", int'(LCD_E), 0);
        check("mid_rst_bus", int'({LCD_RS, LCD_data}), 0);
        check("mid_rst_ready", int'(req_ready), 0);
        check("mid_rst_done", int'(init_done), 0);
        reset = 1'b0;
        run_init();

        check("rw_low", rw_bad, 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
